// File: rtl/bitstream_packer.sv
// bitstream_packer
//   Packs left-aligned variable-length code fields into a big-endian byte
//   stream, optionally stuffs 0x00 after every 0xFF byte, pads the last
//   byte of a frame with 1s and hands out 32-bit words with a byte count
//   and a last-of-frame flag.
//
//   Optional feature macro: BITSTREAM_PACKER_STUFF_EN
//     defined   -> a 0x00 byte is inserted after every 0xFF byte
//     undefined -> 0xFF bytes pass unchanged (raw bitstream)
//
// Ports
//   clk                  clock
//   resetn               asynchronous reset, active low
//   in_codecoeff_length  valid bits in in_codecoeff (0..52)
//   in_codecoeff         field, bit 51 sent first
//   in_tlast             field closes the frame
//   in_valid / in_hold   input handshake (accept = in_valid & !in_hold)
//   out_data             packed bytes, first byte in [31:24]
//   out_nbytes           valid bytes in out_data (1..4)
//   out_tlast            last word of the frame
//   out_valid / out_hold output handshake (consume = out_valid & !out_hold)
module bitstream_packer (
  input  logic        clk,
  input  logic        resetn,
  input  logic [5:0]  in_codecoeff_length,
  input  logic [51:0] in_codecoeff,
  input  logic        in_tlast,
  input  logic        in_valid,
  output logic        in_hold,
  output logic [31:0] out_data,
  output logic [2:0]  out_nbytes,
  output logic        out_tlast,
  output logic        out_valid,
  input  logic        out_hold
);

`ifdef BITSTREAM_PACKER_STUFF_EN
  localparam bit StuffEn = 1'b1;
`else
  localparam bit StuffEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_STUFF,
    SRC_EXTRACT,
    SRC_PAD
  } src_e;

  // bit accumulator: valid bits are left-aligned, everything below fill is 0
  logic [95:0] acc_q, acc_d;
  logic [6:0]  fill_q, fill_d;
  logic        flush_q, flush_d;
  logic        stuff_q, stuff_d;
  // word assembler doubles as the output register
  logic [31:0] word_q, word_d;
  logic [2:0]  nb_q, nb_d;
  logic        valid_q, valid_d;
  logic        tlast_q, tlast_d;
  logic [2:0]  onb_q, onb_d;

  logic        accept, consume, en, wr;
  logic        flush_nx, drained;
  src_e        src;
  logic [7:0]  byte_v;
  logic [95:0] acc_sh, fld96;
  logic [6:0]  fill_sh;
  logic [51:0] fmask;
  logic [2:0]  nb_eff, nb_new;

  assign in_hold = (fill_q > 7'd44) | flush_q;
  assign accept  = in_valid & ~in_hold;
  assign consume = valid_q & ~out_hold;

  // Byte stage stalls while the output word is held downstream, and also
  // while a completed word is parked (see the completion logic below).
  assign en = ~(valid_q & out_hold) & ~((nb_q == 3'd4) & ~valid_q);

  // keep only the top 'length' bits of the field
  assign fmask = ~(52'hF_FFFF_FFFF_FFFF >> in_codecoeff_length);
  assign fld96 = {in_codecoeff & fmask, 44'h0};

  always_comb begin
    src      = SRC_NONE;
    byte_v   = 8'h00;
    acc_sh   = acc_q;
    fill_sh  = fill_q;
    stuff_d  = stuff_q;
    acc_d    = acc_q;
    fill_d   = fill_q;
    flush_nx = flush_q | (accept & in_tlast);
    flush_d  = flush_nx;
    nb_eff   = consume ? 3'd0 : nb_q;
    word_d   = word_q;
    valid_d  = valid_q;
    tlast_d  = tlast_q;
    onb_d    = onb_q;

    // ---- byte source selection, priority STUFF > EXTRACT > PAD ----
    if (en) begin
      if (stuff_q)                         src = SRC_STUFF;
      else if (fill_q >= 7'd8)             src = SRC_EXTRACT;
      else if (flush_q && fill_q != 7'd0)  src = SRC_PAD;
    end

    case (src)
      SRC_STUFF: begin
        byte_v  = 8'h00;
        stuff_d = 1'b0;
      end
      SRC_EXTRACT: begin
        byte_v  = acc_q[95:88];
        acc_sh  = acc_q << 8;
        fill_sh = fill_q - 7'd8;
      end
      SRC_PAD: begin
        // bits below the fill are zero, so OR-ing ones fills the tail
        byte_v  = acc_q[95:88] | (8'hFF >> fill_q);
        acc_sh  = '0;
        fill_sh = '0;
      end
      default: ;
    endcase

    if (src == SRC_EXTRACT || src == SRC_PAD)
      stuff_d = StuffEn && (byte_v == 8'hFF);

    wr = (src != SRC_NONE);

    // ---- accumulator: append new field directly below remaining bits ----
    acc_d  = acc_sh;
    fill_d = fill_sh;
    if (accept) begin
      acc_d  = acc_sh | (fld96 >> fill_sh);
      fill_d = fill_sh + {1'b0, in_codecoeff_length};
    end

    // ---- word assembler ----
    if (nb_eff == 3'd0) word_d = '0;
    if (wr) begin
      case (nb_eff)
        3'd0:    word_d[31:24] = byte_v;
        3'd1:    word_d[23:16] = byte_v;
        3'd2:    word_d[15:8]  = byte_v;
        default: word_d[7:0]   = byte_v;
      endcase
    end
    nb_new = nb_eff + {2'b00, wr};
    nb_d   = nb_new;

    // nothing left to write after this edge
    drained = (fill_d == 7'd0) & ~stuff_d;

    // ---- completion / flush ----
    // A full word with no bits behind it is parked (valid low) until we
    // know whether more data follows or the frame ends, so that a late
    // zero-length tlast field can still mark it as the last word.
    if (!(valid_q && out_hold)) begin
      valid_d = 1'b0;
      tlast_d = 1'b0;
      if (nb_new == 3'd4) begin
        if (!drained) begin
          valid_d = 1'b1;
          onb_d   = 3'd4;
        end else if (flush_nx) begin
          valid_d = 1'b1;
          tlast_d = 1'b1;
          onb_d   = 3'd4;
        end
      end else if (drained && flush_nx) begin
        if (nb_new != 3'd0) begin
          valid_d = 1'b1;
          tlast_d = 1'b1;
          onb_d   = nb_new;
        end else begin
          // empty frame: nothing to emit, just end the flush
          flush_d = 1'b0;
        end
      end
      if (consume && tlast_q) flush_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q   <= '0;
      fill_q  <= '0;
      flush_q <= 1'b0;
      word_q  <= '0;
      nb_q    <= '0;
      valid_q <= 1'b0;
      tlast_q <= 1'b0;
      onb_q   <= '0;
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      flush_q <= flush_d;
      word_q  <= word_d;
      nb_q    <= nb_d;
      valid_q <= valid_d;
      tlast_q <= tlast_d;
      onb_q   <= onb_d;
    end
  end

`ifdef BITSTREAM_PACKER_STUFF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) stuff_q <= 1'b0;
    else         stuff_q <= stuff_d;
  end
`else
  assign stuff_q = 1'b0;
`endif

  assign out_data   = word_q;
  assign out_nbytes = onb_q;
  assign out_tlast  = tlast_q;
  assign out_valid  = valid_q;

  // field lengths above 52 are outside the legal range
  always_ff @(posedge clk) begin
    if (resetn && in_valid) assert (in_codecoeff_length <= 6'd52);
  end

endmodule

// File: tb/tb_bitstream_packer.sv
module tb_bitstream_packer;
  logic clk = 1'b0;
  logic resetn;
  logic [5:0]  len;
  logic [51:0] cc;
  logic tl, iv, ih, ot, ov, oh;
  logic [31:0] od;
  logic [2:0]  onb;

  always #5 clk = ~clk;

  bitstream_packer dut (
    .clk(clk), .resetn(resetn),
    .in_codecoeff_length(len), .in_codecoeff(cc), .in_tlast(tl),
    .in_valid(iv), .in_hold(ih),
    .out_data(od), .out_nbytes(onb), .out_tlast(ot),
    .out_valid(ov), .out_hold(oh)
  );

`ifdef BITSTREAM_PACKER_STUFF_EN
  localparam bit STUFF = 1'b1;
`else
  localparam bit STUFF = 1'b0;
`endif

  typedef struct { logic [5:0] len; logic [51:0] val; logic tlast; } fld_t;
  typedef struct { logic [31:0] data; logic [2:0] nb; logic tlast; } wrd_t;
  typedef struct { int nf; fld_t f[2]; int nw; wrd_t w[2]; } vec_t;

  fld_t fq[$];
  wrd_t got[$];
  wrd_t exp_q[$];
  int checks = 0, failures = 0;
  int vld_pct = 100, hold_pct = 0;
  int ncyc = 0, first_acc = -1, first_val = -1;
  logic prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [2:0]  prev_nb;
  logic        prev_tl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // reference: concatenate bits, cut into bytes padding with 1s, stuff, cut into words
  task automatic build_exp();
    bit bits[$];
    logic [7:0] bytes[$];
    exp_q.delete();
    foreach (fq[k])
      for (int i = 0; i < int'(fq[k].len); i++) bits.push_back(fq[k].val[51-i]);
    while (bits.size() != 0) begin
      logic [7:0] b = 8'hFF;
      for (int i = 0; i < 8; i++)
        if (bits.size() != 0) b[7-i] = bits.pop_front();
      bytes.push_back(b);
      if (STUFF && b == 8'hFF) bytes.push_back(8'h00);
    end
    for (int i = 0; i < bytes.size(); i += 4) begin
      wrd_t w;
      w.data = '0;
      w.nb = 3'd0;
      for (int j = 0; j < 4; j++)
        if (i + j < bytes.size()) begin
          w.data[31-8*j -: 8] = bytes[i+j];
          w.nb = w.nb + 3'd1;
        end
      w.tlast = (i + 4 >= bytes.size());
      exp_q.push_back(w);
    end
  endtask

  task automatic start_frame();
    got.delete();
    first_acc = -1;
    first_val = -1;
  endtask

  // one clock: drive at negedge, evaluate handshakes for the coming edge
  task automatic cyc();
    fld_t d;
    @(negedge clk);
    ncyc++;
    oh = ($urandom_range(99) < hold_pct);
    if (fq.size() != 0 && $urandom_range(99) < vld_pct) begin
      iv = 1'b1; len = fq[0].len; cc = fq[0].val; tl = fq[0].tlast;
    end else begin
      iv = 1'b0; len = '0; cc = '0; tl = 1'b0;
    end
    if (prev_stall) begin
      chk("held_out_data", od, prev_data);
      chk("held_out_nbytes", onb, prev_nb);
      chk("held_out_tlast", ot, prev_tl);
    end
    prev_stall = ov && oh;
    prev_data = od; prev_nb = onb; prev_tl = ot;
    if (iv && !ih) begin
      d = fq.pop_front();
      if (first_acc < 0) first_acc = ncyc;
    end
    if (ov && first_val < 0) first_val = ncyc;
    if (ov && !oh) got.push_back('{od, onb, ot});
  endtask

  task automatic run_frame(input string name, input int budget);
    int n = 0, idle = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      cyc();
      n++;
      if (fq.size() == 0) idle++;
      if (exp_q.size() == 0) done = (fq.size() == 0) && idle >= 10;
      else done = (fq.size() == 0) && got.size() != 0 && got[got.size()-1].tlast;
    end
    chk({name, "_completes"}, done, 1);
    chk({name, "_nwords"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s_w%0d_data", name, i), got[i].data, exp_q[i].data);
      chk($sformatf("%s_w%0d_nbytes", name, i), got[i].nb, exp_q[i].nb);
      chk($sformatf("%s_w%0d_tlast", name, i), got[i].tlast, exp_q[i].tlast);
    end
  endtask

  vec_t tbl[4];

  initial begin
    resetn = 1'b1; iv = 1'b0; len = '0; cc = '0; tl = 1'b0; oh = 1'b0;
    #1 resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_hold", ih, 0);
    chk("rst_out_valid", ov, 0);
    chk("rst_out_tlast", ot, 0);
    chk("rst_out_nbytes", onb, 0);
    chk("rst_out_data", od, 0);
    resetn = 1'b1;

    // ---- directed vectors ----
    tbl[0].nf = 2;
    tbl[0].f[0] = '{6'd32, 52'h1234567800000, 1'b0};
    tbl[0].f[1] = '{6'd0, 52'h0, 1'b1};
    tbl[0].nw = 1;
    tbl[0].w[0] = '{32'h12345678, 3'd4, 1'b1};
    tbl[1].nf = 2;
    tbl[1].f[0] = '{6'd16, 52'hFFA5000000000, 1'b0};
    tbl[1].f[1] = '{6'd16, 52'h1234000000000, 1'b1};
`ifdef BITSTREAM_PACKER_STUFF_EN
    tbl[1].nw = 2;
    tbl[1].w[0] = '{32'hFF00A512, 3'd4, 1'b0};
    tbl[1].w[1] = '{32'h34000000, 3'd1, 1'b1};
`else
    tbl[1].nw = 1;
    tbl[1].w[0] = '{32'hFFA51234, 3'd4, 1'b1};
`endif
    tbl[2].nf = 1;
    tbl[2].f[0] = '{6'd3, 52'hA000000000000, 1'b1};
    tbl[2].nw = 1;
    tbl[2].w[0] = '{32'hBF000000, 3'd1, 1'b1};
    tbl[3].nf = 1;
    tbl[3].f[0] = '{6'd5, 52'hF800000000000, 1'b1};
    tbl[3].nw = 1;
`ifdef BITSTREAM_PACKER_STUFF_EN
    tbl[3].w[0] = '{32'hFF000000, 3'd2, 1'b1};
`else
    tbl[3].w[0] = '{32'hFF000000, 3'd1, 1'b1};
`endif

    hold_pct = 0; vld_pct = 100;
    for (int i = 0; i < 4; i++) begin
      start_frame();
      for (int j = 0; j < tbl[i].nf; j++) fq.push_back(tbl[i].f[j]);
      exp_q.delete();
      for (int j = 0; j < tbl[i].nw; j++) exp_q.push_back(tbl[i].w[j]);
      run_frame($sformatf("vec%0d", i), 200);
      // first field accepted at edge 0 -> out_valid visible after edge 4
      if (i == 0) chk("latency_negedges", first_val - first_acc, 5);
    end

    // ---- downstream stall while full-length fields stream in ----
    start_frame();
    for (int i = 0; i < 6; i++)
      fq.push_back('{6'd52, {$urandom, $urandom_range(20'hFFFFF)}, (i == 5)});
    build_exp();
    hold_pct = 100;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (first_acc >= 0 && ncyc == first_acc + 1) chk("in_hold_after_first_52", ih, 1);
    end
    chk("stall_in_hold", ih, 1);
    chk("stall_out_valid", ov, 1);
    hold_pct = 0;
    run_frame("stall", 500);

    // ---- reset in the middle of a frame ----
    start_frame();
    fq.push_back('{6'd20, 52'hABCDE00000000, 1'b0});
    repeat (3) cyc();
    @(negedge clk);
    resetn = 1'b0;
    iv = 1'b0;
    #1;
    chk("midrst_in_hold", ih, 0);
    chk("midrst_out_valid", ov, 0);
    chk("midrst_out_tlast", ot, 0);
    chk("midrst_out_nbytes", onb, 0);
    chk("midrst_out_data", od, 0);
    @(negedge clk);
    resetn = 1'b1;
    prev_stall = 1'b0;
    fq.delete();
    start_frame();
    fq.push_back('{6'd8, 52'h5A00000000000, 1'b1});
    exp_q.delete();
    exp_q.push_back('{32'h5A000000, 3'd1, 1'b1});
    run_frame("after_rst", 100);

    // ---- randomized frames against the reference ----
    for (int f = 0; f < 25; f++) begin
      int nf = $urandom_range(1, 6);
      bit ones = ($urandom_range(4) == 0);
      start_frame();
      for (int i = 0; i < nf; i++) begin
        fld_t x;
        int r = $urandom_range(9);
        x.len = (r == 0) ? 6'd0 : (r == 1) ? 6'd52 : 6'($urandom_range(1, 52));
        x.val = ones ? '1 : {$urandom, $urandom_range(20'hFFFFF)};
        x.tlast = (i == nf - 1);
        fq.push_back(x);
      end
      build_exp();
      hold_pct = $urandom_range(0, 70);
      vld_pct = $urandom_range(40, 100);
      run_frame($sformatf("rnd%0d", f), 3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bitstream_packer.md
# bitstream_packer

Receiver for the JPEG encoder's packed code+coefficient stream. It concatenates variable-length, left-aligned bit fields into a continuous big-endian bitstream and inserts a 0x00 after every 0xFF byte (JPEG byte stuffing). At end of frame it pads the last byte with 1s and emits 32-bit words with a byte count and a last flag. It sits between the entropy coder and the JPEG header/output muxing logic.

## Interface
Parameters: none.

Ports:
- clk  in  1  sole clock
- resetn  in  1  reset, asynchronous, active-low
- in_codecoeff_length  in  6  number of valid bits in in_codecoeff, 0..52
- in_codecoeff  in  52  field, MSB-first, left-aligned (bit 51 is sent first); bits below the length are don't-care
- in_tlast  in  1  field is the last of the frame
- in_valid  in  1  input field present
- in_hold  out  1  stall; a field is accepted on an edge where in_valid & !in_hold
- out_data  out  32  packed bytes, first byte in [31:24]
- out_nbytes  out  3  valid bytes in out_data, 1..4; always 4 unless out_tlast
- out_tlast  out  1  final word of the frame
- out_valid  out  1  out_data valid
- out_hold  in  1  downstream stall; a word is consumed on an edge where out_valid & !out_hold

## Operation
- The bit accumulator is 96 bits wide with a 7-bit fill count. An accepted field is appended directly below the existing fill.
- in_hold = (fill > 44) | flush_pending. It is combinational from registered state only and must not depend on in_valid.
- Byte stage: at most one byte is written per edge, into the word assembler. It is enabled when !(out_valid & out_hold). Source priority:
  - STUFF: the previous written byte was 0xFF, so write 0x00 and consume no bits.
  - EXTRACT: fill >= 8, so take the top 8 bits, shift left, and subtract 8 from fill.
  - PAD: flush_pending & 0 < fill < 8, so take the top fill bits and pad the rest with 1s; fill becomes 0.
- A padded 0xFF byte is also stuffed.
- The fill update on an edge is fill − 8·extract + len·accept. Accept and extract can occur on the same edge.
- Word assembler: byte slots are filled from [31:24] down.
  - When the 4th byte is written, out_valid is set and out_nbytes = 4.
  - A byte written on the same edge that consumes a word starts the next word.
- Flush:
  - Accepting a field with in_tlast sets flush_pending. No further input is accepted.
  - Flush completes once fill = 0, no STUFF is pending, and the assembler holds k bytes.
  - If k > 0 (1..4), that word is emitted with out_tlast = 1 and out_nbytes = k; unused low bytes are 0x00.
  - If k = 0 (word boundary), the last full word emitted carries out_tlast = 1. If that word was already issued, the marking is deferred by holding it: the 4th byte sets out_valid only after flush is known. Concretely, out_tlast is registered together with the word when flush_pending & fill = 0 & no STUFF pending at the edge where the word completes.
  - flush_pending clears on the edge the tlast word is consumed.
- A zero-length field is legal. It adds no bits; its tlast is honored.
- Length > 52 is illegal. The simulation assertion fires and the behaviour is undefined.

## Timing
- Reset values: in_hold 0, out_valid 0, out_tlast 0, out_nbytes 0, out_data 0. Internally fill 0, flush_pending 0, STUFF clear.
- A reset mid-frame discards all buffered bits and the partial word. No output is produced until new input arrives.
- Latency: a 32-bit field accepted at edge 0 with out_hold low produces out_valid visible after edge 4, one byte per edge.
- Throughput: 1 byte/edge; each stuffed 0x00 costs one edge.
- out_data, out_nbytes and out_tlast are stable while out_valid & out_hold.
- Downstream may hold for any number of cycles. No bit is lost or reordered.

## Configuration
- BITSTREAM_PACKER_STUFF_EN defined: 0x00 insertion after 0xFF is active, as described above.
- Undefined: the STUFF state is removed and 0xFF bytes pass unchanged. This gives a raw bitstream for bit-exact comparison against the coder's model. Padding and flush are unchanged.

## Test plan
- Field len 32, value 0x12345678 in [51:20], tlast 0, then len 0 with tlast 1 → one word 0x12345678, nbytes 4, tlast 1.
- Fields len 16 0xFFA5, len 16 0x1234, tlast on the second (STUFF_EN defined) → 0xFF00A512 nbytes 4 tlast 0, then 0x34000000 nbytes 1 tlast 1. With the macro undefined → 0xFFA51234 nbytes 4 tlast 1.
- Single field len 3 = 0b101, tlast → 0xBF000000, nbytes 1, tlast 1.
- Single field len 5 = 0b11111, tlast (STUFF_EN) → 0xFF000000, nbytes 2, tlast 1.
- out_hold high for 20 cycles while len-52 fields stream in:
  - in_hold asserts on the first edge fill > 44.
  - After release, the output equals the reference concatenation byte-for-byte.
  - out_data does not change while held.
- Assert resetn low for 1 cycle mid-frame with 20 bits buffered:
  - All outputs return to reset values.
  - A following len-8 0x5A tlast field yields 0x5A000000 nbytes 1 tlast 1.
